parking_ledger: RTL and testbench

- Clocked, parametrised successor to the parking check-in/check-out block. It tracks occupancy and check-in time for NUM_SLOTS bays.
- A single press-driven front end checks a bay in or out. Check-out computes the fee as whole started hours times a rate, using a multi-cycle subtract-based divider.
- Sits between the debounced button/selector front panel and the fee display / occupancy LEDs.

---
 rtl/parking_pkg.sv | 19 +
 rtl/parking_fee_calc.sv | 62 ++++++
 rtl/parking_ledger.sv | 160 ++++++++++++++++
 tb/tb_parking_ledger.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types, default billing constants and the bay-number range check
// for the parking ledger.
package parking_pkg;

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  localparam int unsigned DEF_MIN_PER_HOUR = 60;
  localparam int unsigned DEF_RATE         = 10;
  localparam int unsigned DEF_GRACE_MIN    = 15;

  // Bays are numbered 1..n; 0 and anything above n are invalid.
  function automatic logic slot_ok(input int unsigned sel, input int unsigned n);
    return (sel != 0) && (sel <= n);
  endfunction

endpackage

// File: rtl/parking_fee_calc.sv
// Fee engine: counts started hours by repeated subtraction, then multiplies
// by the rate. i_zero posts a zero fee directly, bypassing the hour count.
module parking_fee_calc
  import parking_pkg::*;
#(
  parameter int unsigned TIME_W       = 11,
  parameter int unsigned FEE_W        = 11,
  parameter int unsigned MIN_PER_HOUR = DEF_MIN_PER_HOUR,
  parameter int unsigned RATE         = DEF_RATE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_zero,
  input  logic [TIME_W-1:0] i_rem,
  output logic              o_finish,
  output logic [FEE_W-1:0]  o_fee,
  output logic              o_fee_valid
);

  localparam int unsigned PROD_W = FEE_W + TIME_W;

  logic              r_active;
  logic [TIME_W-1:0] r_rem;
  logic [TIME_W-1:0] r_hours;
  logic [PROD_W-1:0] w_prod;

  assign o_finish = r_active && (r_rem == '0);
  assign w_prod   = PROD_W'(r_hours) * PROD_W'(RATE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_active    <= 1'b0;
      r_rem       <= '0;
      r_hours     <= '0;
      o_fee       <= '0;
      o_fee_valid <= 1'b0;
    end else begin
      o_fee_valid <= 1'b0;
      if (i_start) begin
        r_active <= 1'b1;
        r_rem    <= i_rem;
        r_hours  <= '0;
      end else if (r_active) begin
        if (r_rem != '0) begin
          // A partial final hour is billed as a whole one.
          r_hours <= r_hours + 1'b1;
          r_rem   <= (r_rem > TIME_W'(MIN_PER_HOUR)) ? r_rem - TIME_W'(MIN_PER_HOUR) : '0;
        end else begin
          o_fee       <= w_prod[FEE_W-1:0];
          o_fee_valid <= 1'b1;
          r_active    <= 1'b0;
        end
      end
      if (i_zero) begin
        o_fee       <= '0;
        o_fee_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_ledger.sv
// Parking bay ledger: edge-detected check-in/check-out, per-bay time storage,
// fee via parking_fee_calc. Optional macro PARKING_LEDGER_GRACE_EN adds a free period.
module parking_ledger
  import parking_pkg::*;
#(
  parameter int unsigned NUM_SLOTS    = 6,
  parameter int unsigned SEL_W        = 4,
  parameter int unsigned TIME_W       = 11,
  parameter int unsigned FEE_W        = 11,
  parameter int unsigned MIN_PER_HOUR = DEF_MIN_PER_HOUR,
  parameter int unsigned RATE         = DEF_RATE,
  parameter int unsigned GRACE_MIN    = DEF_GRACE_MIN
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          press,
  input  logic                          free,
  input  logic [SEL_W-1:0]              selector,
  input  logic [TIME_W-1:0]             timer,
  output logic [NUM_SLOTS-1:0]          occupied,
  output logic [NUM_SLOTS*TIME_W-1:0]   checkin_times,
  output logic [FEE_W-1:0]              fee,
  output logic                          fee_valid,
  output logic                          ack,
  output logic                          err,
  output logic                          busy
);

  state_t r_state, w_state_nxt;

  logic                 r_press_d;
  logic [NUM_SLOTS-1:0] r_occ;
  logic [TIME_W-1:0]    r_times [NUM_SLOTS];
  logic                 r_ack, r_err, r_start, r_zero;
  logic [TIME_W-1:0]    r_rem;

  logic                 w_cmd, w_sel_ok, w_occ_hit, w_grace, w_finish;
  logic [NUM_SLOTS-1:0] w_hit;
  logic [TIME_W-1:0]    w_stored, w_rem;
  logic                 w_do_in, w_do_out, w_ack_nxt, w_err_nxt, w_start, w_zero;

  assign w_cmd    = press && !r_press_d;
  assign w_sel_ok = slot_ok(32'(selector), NUM_SLOTS);
  assign w_rem    = timer - w_stored;

  always_comb begin
    w_hit     = '0;
    w_stored  = '0;
    w_occ_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (selector == SEL_W'(i + 1)) begin
        w_hit[i]  = 1'b1;
        w_stored  = r_times[i];
        w_occ_hit = r_occ[i];
      end
    end
  end

  always_comb begin
`ifdef PARKING_LEDGER_GRACE_EN
    w_grace = (w_rem <= TIME_W'(GRACE_MIN));
`else
    w_grace = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_do_in     = 1'b0;
    w_do_out    = 1'b0;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_start     = 1'b0;
    w_zero      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cmd) begin
          if (!w_sel_ok || (free == w_occ_hit)) begin
            w_err_nxt = 1'b1;
          end else if (free) begin
            w_do_in   = 1'b1;
            w_ack_nxt = 1'b1;
          end else begin
            w_do_out  = 1'b1;
            w_ack_nxt = 1'b1;
            if (w_grace) begin
              w_zero = 1'b1;
            end else begin
              w_start     = 1'b1;
              w_state_nxt = CALC;
            end
          end
        end
      end
      CALC: if (w_finish) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_press_d <= 1'b0;
      r_occ     <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_start   <= 1'b0;
      r_zero    <= 1'b0;
      r_rem     <= '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) r_times[i] <= '0;
    end else begin
      r_press_d <= press;
      r_ack     <= w_ack_nxt;
      r_err     <= w_err_nxt;
      r_start   <= w_start;
      r_zero    <= w_zero;
      r_rem     <= w_rem;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (w_hit[i] && w_do_in) begin
          r_occ[i]   <= 1'b1;
          r_times[i] <= timer;
        end else if (w_hit[i] && w_do_out) begin
          r_occ[i]   <= 1'b0;
          r_times[i] <= '0;
        end
      end
    end
  end

  parking_fee_calc #(
    .TIME_W       (TIME_W),
    .FEE_W        (FEE_W),
    .MIN_PER_HOUR (MIN_PER_HOUR),
    .RATE         (RATE)
  ) u_fee_calc (
    .clk         (clk),
    .reset       (reset),
    .i_start     (r_start),
    .i_zero      (r_zero),
    .i_rem       (r_rem),
    .o_finish    (w_finish),
    .o_fee       (fee),
    .o_fee_valid (fee_valid)
  );

  always_comb begin
    checkin_times = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) checkin_times[i*TIME_W +: TIME_W] = r_times[i];
  end

  assign occupied = r_occ;
  assign ack      = r_ack;
  assign err      = r_err;
  assign busy     = (r_state == CALC);

endmodule

// File: tb/tb_parking_ledger.sv
// Scoreboard bench for parking_ledger: stimulus pushes expected ack/err/fee
// events with their cycle numbers; a monitor pops and compares them.
module tb_parking_ledger;

  localparam int EV_ACK = 0;
  localparam int EV_ERR = 1;
  localparam int EV_FEE = 2;
  localparam int NONE   = -1;

  logic        clk = 1'b0;
  logic        reset, press, free;
  logic [3:0]  selector;
  logic [10:0] timer;
  logic [5:0]  occupied;
  logic [65:0] checkin_times;
  logic [10:0] fee;
  logic        fee_valid, ack, err, busy;

  parking_ledger #(
    .NUM_SLOTS (6),
    .SEL_W     (4),
    .TIME_W    (11),
    .FEE_W     (11)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .press         (press),
    .free          (free),
    .selector      (selector),
    .timer         (timer),
    .occupied      (occupied),
    .checkin_times (checkin_times),
    .fee           (fee),
    .fee_valid     (fee_valid),
    .ack           (ack),
    .err           (err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int cyc;
    int fee;
  } ev_t;
  ev_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int c, input int f);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.fee  = f;
    sb.push_back(e);
  endtask

  task automatic pop_check(input int kind, input string name);
    ev_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_%s: got pulse at cycle %0d, expected none", name, cyc);
    end else begin
      e = sb.pop_front();
      chk({name, "_kind"}, 64'(kind), 64'(e.kind));
      chk({name, "_cycle"}, 64'(cyc), 64'(e.cyc));
      if (kind == EV_FEE) chk("fee_value", 64'(fee), 64'(e.fee));
    end
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ack)       pop_check(EV_ACK, "ack");
      if (err)       pop_check(EV_ERR, "err");
      if (fee_valid) pop_check(EV_FEE, "fee_valid");
    end
  end

  // One press; expected response kind and fee latency relative to the accepting edge.
  task automatic cmd(input logic f, input logic [3:0] s, input logic [10:0] t,
                     input int resp, input int lat, input int exp_fee);
    int k;
    @(negedge clk);
    free     = f;
    selector = s;
    timer    = t;
    k        = cyc + 1;
    if (resp != NONE) push(resp, k, 0);
    if (lat != NONE)  push(EV_FEE, k + lat, exp_fee);
    press = 1'b1;
    @(negedge clk);
    press = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(name, 64'(busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; press = 1'b0; free = 1'b0; selector = '0; timer = '0;
    repeat (2) @(negedge clk);
    chk("rst_occupied", 64'(occupied), 64'd0);
    chk("rst_times", 64'(checkin_times), 64'd0);
    chk("rst_fee", 64'(fee), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pulses", 64'({ack, err, fee_valid}), 64'd0);
    reset = 1'b0;

    cmd(1'b1, 4'd1, 11'd100, EV_ACK, NONE, 0);
    chk("in1_occupied", 64'(occupied), 64'b000001);
    chk("in1_time", 64'(checkin_times[10:0]), 64'd100);

    cmd(1'b0, 4'd1, 11'd221, EV_ACK, 5, 30);
    wait_idle("out1_idle");
    chk("out1_occupied", 64'(occupied), 64'd0);
    chk("out1_time", 64'(checkin_times[10:0]), 64'd0);
    chk("out1_fee", 64'(fee), 64'd30);

    cmd(1'b1, 4'd2, 11'd120, EV_ACK, NONE, 0);
    chk("in2_time", 64'(checkin_times[21:11]), 64'd120);
    cmd(1'b0, 4'd2, 11'd180, EV_ACK, 3, 10);
    wait_idle("exact60_idle");

    cmd(1'b1, 4'd2, 11'd500, EV_ACK, NONE, 0);
`ifdef PARKING_LEDGER_GRACE_EN
    cmd(1'b0, 4'd2, 11'd500, EV_ACK, 1, 0);
`else
    cmd(1'b0, 4'd2, 11'd500, EV_ACK, 2, 0);
`endif
    wait_idle("zero_use_idle");
    chk("zero_use_fee", 64'(fee), 64'd0);

    cmd(1'b1, 4'd3, 11'd2040, EV_ACK, NONE, 0);
    cmd(1'b0, 4'd3, 11'd20, EV_ACK, 3, 10);
    wait_idle("wrap_idle");
    chk("wrap_times", 64'(checkin_times), 64'd0);

    cmd(1'b1, 4'd0, 11'd5, EV_ERR, NONE, 0);
    cmd(1'b1, 4'd7, 11'd5, EV_ERR, NONE, 0);
    chk("badsel_occupied", 64'(occupied), 64'd0);
    cmd(1'b1, 4'd1, 11'd300, EV_ACK, NONE, 0);
    cmd(1'b1, 4'd1, 11'd400, EV_ERR, NONE, 0);
    chk("dup_in_time", 64'(checkin_times[10:0]), 64'd300);
    cmd(1'b0, 4'd5, 11'd400, EV_ERR, NONE, 0);
    chk("empty_out_fee", 64'(fee), 64'd10);
    chk("empty_out_occupied", 64'(occupied), 64'b000001);

    // Second press lands while the fee is being computed and must vanish.
    cmd(1'b0, 4'd1, 11'd421, EV_ACK, 5, 30);
    cmd(1'b1, 4'd5, 11'd421, NONE, NONE, 0);
    wait_idle("drop_idle");
    chk("drop_occupied", 64'(occupied), 64'd0);

    @(negedge clk);
    free = 1'b1; selector = 4'd6; timer = 11'd7;
    push(EV_ACK, cyc + 1, 0);
    press = 1'b1;
    repeat (4) @(negedge clk);
    press = 1'b0;
    chk("held_occupied", 64'(occupied), 64'b100000);
    chk("held_time", 64'(checkin_times[65:55]), 64'd7);

    cmd(1'b0, 4'd6, 11'd307, EV_ACK, NONE, 0);
    repeat (2) @(negedge clk);
    chk("midcalc_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_fee", 64'(fee), 64'd0);
    repeat (10) @(negedge clk);
    chk("abort_still_idle", 64'(busy), 64'd0);

`ifdef PARKING_LEDGER_GRACE_EN
    cmd(1'b1, 4'd1, 11'd1000, EV_ACK, NONE, 0);
    cmd(1'b0, 4'd1, 11'd1015, EV_ACK, 1, 0);
    chk("grace15_busy", 64'(busy), 64'd0);
    cmd(1'b1, 4'd1, 11'd1000, EV_ACK, NONE, 0);
    cmd(1'b0, 4'd1, 11'd1016, EV_ACK, 3, 10);
    wait_idle("grace16_idle");
    chk("grace16_fee", 64'(fee), 64'd10);
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
